// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, write-engine state encoding and row-base helper.
// The frame buffer itself imports the same geometry.
package fb_pkg;

  localparam int FB_WIDTH   = 640;
  localparam int FB_HEIGHT  = 480;
  localparam int ADDR_WIDTH = 19;
  localparam int DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_FILL   = 2'd2,
    ST_FINISH = 2'd3
  } fb_state_t;

  // y*640 as (y<<9)+(y<<7) so no multiplier is inferred.
  function automatic logic [ADDR_WIDTH-1:0] fb_row_base(input logic [8:0] y);
    logic [ADDR_WIDTH-1:0] y_ext;
    y_ext = ADDR_WIDTH'(y);
    return (y_ext << 9) + (y_ext << 7);
  endfunction

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clipper: trims a rectangle to the visible frame and flags
// rectangles with nothing left to draw. Shared with the sprite blitter.
module fb_rect_clip
  import fb_pkg::*;
(
  input  logic [9:0]  i_x,
  input  logic [8:0]  i_y,
  input  logic [9:0]  i_w,
  input  logic [8:0]  i_h,
  output logic [10:0] o_w_eff,
  output logic [10:0] o_h_eff,
  output logic        o_empty
);

  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [10:0] w_w;
  logic [10:0] w_h;
  logic [10:0] w_room_x;
  logic [10:0] w_room_y;

  assign w_x = {1'b0, i_x};
  assign w_y = {2'b00, i_y};
  assign w_w = {1'b0, i_w};
  assign w_h = {2'b00, i_h};

  // Only meaningful when the origin is on-screen; empty masks the rest.
  assign w_room_x = 11'(FB_WIDTH) - w_x;
  assign w_room_y = 11'(FB_HEIGHT) - w_y;

  assign o_empty = (w_x >= 11'(FB_WIDTH)) || (w_y >= 11'(FB_HEIGHT)) ||
                   (i_w == 10'd0) || (i_h == 9'd0);

  assign o_w_eff = o_empty ? 11'd0 : ((w_w < w_room_x) ? w_w : w_room_x);
  assign o_h_eff = o_empty ? 11'd0 : ((w_h < w_room_y) ? w_h : w_room_y);

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill write engine: takes one command per valid/ready handshake and
// streams one registered pixel write per clock, row-major, into the frame buffer.
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic                  i_write_clk,
  input  logic                  i_rst_n,
  // Handshake: a command transfers on a rising edge where i_cmd_valid and
  // o_cmd_ready are both high; o_cmd_ready is high only while idle.
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [9:0]            i_cmd_x,
  input  logic [8:0]            i_cmd_y,
  input  logic [9:0]            i_cmd_w,
  input  logic [8:0]            i_cmd_h,
  input  logic [DATA_WIDTH-1:0] i_cmd_color,
  output logic                  o_write_en,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [DATA_WIDTH-1:0] o_write_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_dbg_state
);

  fb_state_t r_state;
  fb_state_t w_state_nx;

  logic [9:0]            r_x;
  logic [8:0]            r_y;
  logic [9:0]            r_w;
  logic [8:0]            r_h;
  logic [DATA_WIDTH-1:0] r_color;
  logic [10:0]           r_w_eff;
  logic [10:0]           r_h_eff;
  logic [10:0]           r_col;
  logic [10:0]           r_row;
  logic [ADDR_WIDTH-1:0] r_row_start;

  logic                  r_cmd_ready;
  logic                  r_write_en;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_accept;
  logic [10:0]           w_w_eff;
  logic [10:0]           w_h_eff;
  logic                  w_empty;
  logic                  w_last_col;
  logic                  w_last_row;
  logic [ADDR_WIDTH-1:0] w_first_addr;
  logic [ADDR_WIDTH-1:0] w_next_row;

  fb_rect_clip u_clip (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_w     (r_w),
    .i_h     (r_h),
    .o_w_eff (w_w_eff),
    .o_h_eff (w_h_eff),
    .o_empty (w_empty)
  );

  assign w_accept     = (r_state == ST_IDLE) && r_cmd_ready && i_cmd_valid;
  assign w_last_col   = (r_col == r_w_eff - 11'd1);
  assign w_last_row   = (r_row == r_h_eff - 11'd1);
  // r_row_start tracks the address of column 0 of the current row (base + x).
  assign w_first_addr = fb_row_base(r_y) + ADDR_WIDTH'(r_x);
  assign w_next_row   = r_row_start + ADDR_WIDTH'(FB_WIDTH);

  always_ff @(posedge i_write_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nx = ST_SETUP;
      ST_SETUP:  w_state_nx = w_empty ? ST_FINISH : ST_FILL;
      ST_FILL:   if (w_last_col && w_last_row) w_state_nx = ST_FINISH;
      ST_FINISH: w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with it.
  always_ff @(posedge i_write_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_color      <= '0;
      r_w_eff      <= '0;
      r_h_eff      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_row_start  <= '0;
      r_cmd_ready  <= 1'b0;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nx == ST_IDLE);
      r_busy      <= (w_state_nx != ST_IDLE);
      r_done      <= (w_state_nx == ST_FINISH);
      r_write_en  <= (w_state_nx == ST_FILL);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x     <= i_cmd_x;
            r_y     <= i_cmd_y;
            r_w     <= i_cmd_w;
            r_h     <= i_cmd_h;
            r_color <= i_cmd_color;
          end
        end
        ST_SETUP: begin
          r_w_eff <= w_w_eff;
          r_h_eff <= w_h_eff;
          r_col   <= '0;
          r_row   <= '0;
          if (!w_empty) begin
            r_row_start  <= w_first_addr;
            r_write_addr <= w_first_addr;
            r_write_data <= r_color;
          end
        end
        ST_FILL: begin
          if (w_last_col) begin
            // On the final pixel the address is left alone so it never steps past the frame.
            if (!w_last_row) begin
              r_col        <= '0;
              r_row        <= r_row + 11'd1;
              r_row_start  <= w_next_row;
              r_write_addr <= w_next_row;
            end
          end else begin
            r_col        <= r_col + 11'd1;
            r_write_addr <= r_write_addr + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_ready  = r_cmd_ready;
  assign o_write_en   = r_write_en;
  assign o_write_addr = r_write_addr;
  assign o_write_data = r_write_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: directed and random fills checked against a
// pixel-set model of the clipped rectangle, plus handshake and reset timing.
module tb_fb_rect_writer;
  import fb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [9:0]            cmd_x = '0;
  logic [8:0]            cmd_y = '0;
  logic [9:0]            cmd_w = '0;
  logic [8:0]            cmd_h = '0;
  logic [DATA_WIDTH-1:0] cmd_color = '0;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  busy;
  logic                  done;
  logic [1:0]            dbg_state;

  always #5 clk = ~clk;

  fb_rect_writer dut (
    .i_write_clk  (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_x      (cmd_x),
    .i_cmd_y      (cmd_y),
    .i_cmd_w      (cmd_w),
    .i_cmd_h      (cmd_h),
    .i_cmd_color  (cmd_color),
    .o_write_en   (write_en),
    .o_write_addr (write_addr),
    .o_write_data (write_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_WIDTH-1:0] exp_q[$];
  logic [ADDR_WIDTH-1:0] obs_addr[$];
  logic [DATA_WIDTH-1:0] obs_data[$];
  int obs_cyc[$];
  int acc_q[$];
  int done_q[$];
  int cyc = 0;
  int busy_cnt = 0;
  int oob_cnt = 0;
  int rdy_rise = -1;
  logic prev_ready = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: samples on the falling edge, between active edges.
  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      obs_addr.push_back(write_addr);
      obs_data.push_back(write_data);
      obs_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_q.push_back(cyc);
    if (busy === 1'b1) busy_cnt++;
    if (cmd_valid && cmd_ready === 1'b1) acc_q.push_back(cyc);
    if (write_addr > 19'd307199) oob_cnt++;
    if (cmd_ready === 1'b1 && !prev_ready) rdy_rise = cyc;
    prev_ready = (cmd_ready === 1'b1);
  end

  task automatic clear_mon();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    acc_q.delete(); done_q.delete();
    busy_cnt = 0; oob_cnt = 0; rdy_rise = -1;
  endtask

  // Reference: every on-screen pixel of the rectangle, in row-major order.
  task automatic model_fill(input int x, input int y, input int w, input int h);
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (x + c < FB_WIDTH && y + r < FB_HEIGHT)
          exp_q.push_back(ADDR_WIDTH'((y + r) * FB_WIDTH + x + c));
  endtask

  task automatic send_cmd(input int x, input int y, input int w, input int h,
                          input logic [DATA_WIDTH-1:0] c);
    bit got;
    got = 0;
    @(posedge clk); #1;
    cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h); cmd_color = c;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) got = 1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no ready expected ready within 100 cycles");
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      @(negedge clk); #1;
      if (cmd_ready === 1'b1 && busy === 1'b0) idle = 1;
    end
    if (!idle) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: got busy expected idle within 2000 cycles");
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, write_en, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {cmd_ready, write_en, busy, done});
    end
    n_checks++;
    if (write_addr !== '0 || write_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr %0d data %0h expected 0 0", write_addr, write_data);
    end
    n_checks++;
    if (dbg_state !== 2'(ST_IDLE)) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: got %b expected 0", cmd_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ready_after_release: got ready %b busy %b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    clear_mon();
    model_fill(0, 0, 2, 2);
    send_cmd(0, 0, 2, 2, 24'hFF00FF);
    wait_idle();
    n_checks++;
    if (obs_addr.size() != 4 || exp_q.size() != 4) begin
      n_fail++; $display("FAIL basic_count: got %0d expected 4", obs_addr.size());
    end
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_q[i] || obs_data[i] !== 24'hFF00FF) begin
        n_fail++;
        $display("FAIL basic_write%0d: got %0d/%h expected %0d/ff00ff", i, obs_addr[i], obs_data[i], exp_q[i]);
      end
    end
    n_checks++;
    if (obs_cyc.size() == 4 && acc_q.size() == 1 &&
        (obs_cyc[0] != acc_q[0] + 2 || obs_cyc[3] != obs_cyc[0] + 3)) begin
      n_fail++; $display("FAIL basic_timing: got first %0d last %0d expected %0d %0d",
                         obs_cyc[0], obs_cyc[3], acc_q[0] + 2, acc_q[0] + 5);
    end
    n_checks++;
    if (done_q.size() != 1 || acc_q.size() != 1 || done_q[0] != acc_q[0] + 6 || busy_cnt != 6) begin
      n_fail++; $display("FAIL basic_done_busy: got done %0d busy %0d expected 1 pulse, busy 6",
                         done_q.size(), busy_cnt);
    end
  endtask

  task automatic test_corner_clip();
    clear_mon();
    model_fill(638, 479, 5, 3);
    send_cmd(638, 479, 5, 3, 24'h123456);
    wait_idle();
    n_checks++;
    if (obs_addr.size() != exp_q.size()) begin
      n_fail++; $display("FAIL corner_count: got %0d expected %0d", obs_addr.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL corner_addr%0d: got %0d expected %0d", i, obs_addr[i], exp_q[i]);
      end
    end
    n_checks++;
    if (oob_cnt != 0 || done_q.size() != 1) begin
      n_fail++; $display("FAIL corner_bounds: got oob %0d done %0d expected 0 1", oob_cnt, done_q.size());
    end
  endtask

  task automatic test_empty(input int x, input int y, input int w, input int h, input string name);
    clear_mon();
    send_cmd(x, y, w, h, 24'hABCDEF);
    wait_idle();
    n_checks++;
    if (obs_addr.size() != 0) begin
      n_fail++; $display("FAIL %s_writes: got %0d expected 0", name, obs_addr.size());
    end
    n_checks++;
    if (done_q.size() != 1 || acc_q.size() != 1 || done_q[0] != acc_q[0] + 2) begin
      n_fail++; $display("FAIL %s_done: got pulses %0d expected 1 pulse 2 cycles after accept", name, done_q.size());
    end
    n_checks++;
    if (done_q.size() == 1 && rdy_rise != done_q[0] + 1) begin
      n_fail++; $display("FAIL %s_ready: got rise %0d expected %0d", name, rdy_rise, done_q[0] + 1);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    clear_mon();
    @(posedge clk); #1;
    cmd_x = 10'd100; cmd_y = 9'd0; cmd_w = 10'd1; cmd_h = 9'd1; cmd_color = 24'h00AA00;
    cmd_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (cmd_ready === 1'b1) got = 1;
      end
      @(posedge clk); #1;
      cmd_x = 10'd0; cmd_y = 9'd1;
    end
    cmd_valid = 1'b0;
    wait_idle();
    n_checks++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 19'd100 || obs_addr[1] !== 19'd640) begin
      n_fail++; $display("FAIL b2b_addr: got %0d writes expected 100 then 640", obs_addr.size());
    end
    n_checks++;
    if (acc_q.size() != 2 || done_q.size() != 2 || acc_q[1] != done_q[0] + 1 || acc_q[1] != acc_q[0] + 4) begin
      n_fail++; $display("FAIL b2b_timing: got %0d accepts %0d dones expected second accept one edge after FINISH",
                         acc_q.size(), done_q.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    clear_mon();
    send_cmd(10, 20, 4, 4, 24'h0000FF);
    for (int i = 0; i < 50 && obs_addr.size() < 3; i++) begin
      @(negedge clk); #1;
    end
    n_checks++;
    if (obs_addr.size() != 3) begin
      n_fail++; $display("FAIL rst_third_write: got %0d writes expected 3", obs_addr.size());
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({write_en, busy, done, cmd_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_async_clear: got %b expected 0000", {write_en, busy, done, cmd_ready});
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready_release: got %b expected 1", cmd_ready);
    end
    repeat (30) @(negedge clk);
    #1;
    n_checks++;
    if (obs_addr.size() != 0 || done_q.size() != 0) begin
      n_fail++; $display("FAIL rst_abandon: got %0d writes %0d dones expected 0 0", obs_addr.size(), done_q.size());
    end
  endtask

  task automatic test_random();
    int x, y, w, h, n;
    logic [DATA_WIDTH-1:0] c;
    for (int t = 0; t < 25; t++) begin
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(630, 700) : $urandom_range(0, 639);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(470, 500) : $urandom_range(0, 479);
      w = $urandom_range(0, 12);
      h = $urandom_range(0, 6);
      c = DATA_WIDTH'($urandom);
      clear_mon();
      model_fill(x, y, w, h);
      n = exp_q.size();
      send_cmd(x, y, w, h, c);
      wait_idle();
      n_checks++;
      if (obs_addr.size() != n) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d (x%0d y%0d w%0d h%0d)", t, obs_addr.size(), n, x, y, w, h);
      end
      for (int i = 0; i < n && i < obs_addr.size(); i++) begin
        n_checks++;
        if (obs_addr[i] !== exp_q[i] || obs_data[i] !== c || obs_cyc[i] != acc_q[0] + 2 + i) begin
          n_fail++; $display("FAIL rand%0d_write%0d: got %0d/%h@%0d expected %0d/%h@%0d", t, i,
                             obs_addr[i], obs_data[i], obs_cyc[i], exp_q[i], c, acc_q[0] + 2 + i);
        end
      end
      n_checks++;
      if (done_q.size() != 1 || busy_cnt != n + 2 || done_q[0] != acc_q[0] + 2 + n || oob_cnt != 0) begin
        n_fail++; $display("FAIL rand%0d_done: got dones %0d busy %0d oob %0d expected 1 %0d 0", t,
                           done_q.size(), busy_cnt, oob_cnt, n + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corner_clip();
    test_empty(5, 7, 0, 10, "zero_width");
    test_empty(640, 0, 4, 4, "offscreen_x");
    test_empty(3, 480, 4, 4, "offscreen_y");
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
